// File: rtl/tcdm_bank_rr_arbiter_if.sv
// Bus bundle between the masters of one TCDM bank and its arbiter.
// Handshake: a transfer happens in every cycle where req_o and gnt_i are both
// high; req_i/data_i of a master must stay stable until its gnt_o bit is high.
interface tcdm_bank_rr_arbiter_if #(
  parameter int unsigned NumMaster     = 32,
  parameter int unsigned ReqDataWidth  = 32,
  parameter int unsigned RespDataWidth = 32,
  parameter int unsigned IdxWidth      = (NumMaster > 1) ? $clog2(NumMaster) : 1
);
  // Master side
  logic [NumMaster-1:0]                    req_i;
  logic [NumMaster-1:0]                    gnt_o;
  logic [NumMaster-1:0][ReqDataWidth-1:0]  data_i;
  logic [NumMaster-1:0][RespDataWidth-1:0] rdata_o;
  // Bank side
  logic                                    req_o;
  logic                                    gnt_i;
  logic [ReqDataWidth-1:0]                 data_o;
  logic [IdxWidth-1:0]                     idx_o;
  logic [RespDataWidth-1:0]                rdata_i;

  // Arbiter view
  modport slave (
    input  req_i, data_i, gnt_i, rdata_i,
    output gnt_o, rdata_o, req_o, data_o, idx_o
  );

  // Requester/bank (environment) view
  modport master (
    output req_i, data_i, gnt_i, rdata_i,
    input  gnt_o, rdata_o, req_o, data_o, idx_o
  );
endinterface

// File: rtl/tcdm_bank_rr_arbiter.sv
// Round-robin arbiter for one TCDM bank. Zero-latency forward path, optional
// lock-in of the selected master while the bank stalls, broadcast read data.
module tcdm_bank_rr_arbiter #(
  parameter int unsigned NumMaster     = 32,
  parameter int unsigned ReqDataWidth  = 32,
  parameter int unsigned RespDataWidth = 32,
  parameter bit          LockIn        = 1'b1
) (
  input logic                   clk_i,
  input logic                   rst_i,
  tcdm_bank_rr_arbiter_if.slave bus
);
  localparam int unsigned IdxWidth = (NumMaster > 1) ? $clog2(NumMaster) : 1;
  localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(NumMaster - 1);

  logic [IdxWidth-1:0] r_rr;
  logic [IdxWidth-1:0] w_sel;
  logic                w_found;
  int                  w_scan;
  logic                w_lock_valid;
  logic [IdxWidth-1:0] w_lock_idx;
  logic                w_hs;
  logic [NumMaster-1:0] w_gnt;
  logic [NumMaster-1:0][RespDataWidth-1:0] w_rdata;

  assign w_hs = bus.req_o & bus.gnt_i;

  // Lock state exists only when lock-in is enabled.
  if (LockIn) begin : g_lock
    logic                r_lock;
    logic [IdxWidth-1:0] r_lock_idx;

    // A stalled request locks its master; any handshake or idle cycle unlocks.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        r_lock     <= 1'b0;
        r_lock_idx <= '0;
      end else if (w_hs) begin
        r_lock <= 1'b0;
      end else if (bus.req_o) begin
        r_lock     <= 1'b1;
        r_lock_idx <= w_sel;
      end else begin
        r_lock <= 1'b0;
      end
    end

    // A lock whose master has withdrawn is ignored.
    assign w_lock_valid = r_lock & bus.req_i[r_lock_idx];
    assign w_lock_idx   = r_lock_idx;
  end else begin : g_nolock
    assign w_lock_valid = 1'b0;
    assign w_lock_idx   = '0;
  end

  // Select the locked master, else the first requester at or after the pointer.
  always_comb begin
    w_sel   = r_rr;
    w_found = 1'b0;
    w_scan  = 0;
    if (w_lock_valid) begin
      w_sel = w_lock_idx;
    end else begin
      for (int i = 0; i < int'(NumMaster); i++) begin
        w_scan = int'(r_rr) + i;
        if (w_scan >= int'(NumMaster)) w_scan = w_scan - int'(NumMaster);
        if (!w_found && bus.req_i[w_scan]) begin
          w_sel   = IdxWidth'(w_scan);
          w_found = 1'b1;
        end
      end
    end
  end

  // Pointer moves past the granted master; explicit wrap for any NumMaster.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rr <= '0;
    end else if (w_hs) begin
      r_rr <= (w_sel == LastIdx) ? '0 : w_sel + 1'b1;
    end
  end

  // One-hot grant back to the selected master, and read data broadcast.
  always_comb begin
    w_gnt        = '0;
    w_gnt[w_sel] = w_hs;
    for (int m = 0; m < int'(NumMaster); m++) w_rdata[m] = bus.rdata_i;
  end

  assign bus.req_o   = |bus.req_i;
  assign bus.idx_o   = w_sel;
  assign bus.data_o  = bus.data_i[w_sel];
  assign bus.gnt_o   = w_gnt;
  assign bus.rdata_o = w_rdata;
endmodule
